// File: rtl/dpu_apb_csr.sv
// dpu_apb_csr: APB4 completer CSR block for one DPU engine slot
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   PSEL..PSTRB             APB4 request (only PADDR[4:2] decoded)
//   PRDATA/PREADY/PSLVERR   APB response, non-zero only in the ack cycle
//   eng_go                  one-cycle job start pulse
//   eng_src/eng_dst/eng_len job descriptor (SRC_ADDR, DST_ADDR, NUM_BYTES)
//   eng_done/eng_err        engine completion pulse and its error qualifier
//   irq                     registered level interrupt IE & (DONE | ERR)
module dpu_apb_csr #(
    parameter int          P_ADDR_WIDTH = 32,
    parameter logic [31:0] P_VERSION    = 32'h2025_0610,
    parameter logic [31:0] P_LEN_MAX    = 32'h0010_0000
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [P_ADDR_WIDTH-1:0] PADDR,
    input  logic                    PWRITE,
    input  logic [31:0]             PWDATA,
    input  logic [3:0]              PSTRB,
    output logic [31:0]             PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    eng_go,
    output logic [31:0]             eng_src,
    output logic [31:0]             eng_dst,
    output logic [31:0]             eng_len,
    input  logic                    eng_done,
    input  logic                    eng_err,
    output logic                    irq
);
    // The setup phase is the IDLE cycle in which PSEL & !PENABLE is seen, so
    // one wait cycle plus the ack cycle completes a transfer in three cycles.
    typedef enum logic [1:0] {IDLE, ACCESS_WAIT, ACCESS_ACK} apb_t;
    typedef enum logic {JOB_IDLE, JOB_RUN} job_t;
    apb_t        apb_state, apb_next;
    job_t        job_state, job_next;
    logic        ie, done, err;
    logic [2:0]  off;
    logic        ack, busy, go_bit, len_ok, slverr, wr, accept, go_bad, go_busy, w1c;
    logic [31:0] mask, rdata;
    logic        unused_paddr;

    assign unused_paddr = ^{PADDR[P_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign off     = PADDR[4:2];
    assign ack     = apb_state == ACCESS_ACK;
    assign busy    = job_state == JOB_RUN;
    assign go_bit  = PWRITE && off == 3'd1 && PSTRB[0] && PWDATA[0];
    assign len_ok  = eng_len != 32'd0 && eng_len[1:0] == 2'b00 && eng_len <= P_LEN_MAX;
    // GO while busy is an error response that still records ERR.
    assign slverr  = (off[2] && off[1]) || (PWRITE && off == 3'd0) ||
                     (PWRITE && busy && (off == 3'd3 || off == 3'd4 || off == 3'd5)) ||
                     (go_bit && busy);
    assign wr      = ack && PWRITE && !slverr;
    assign accept  = wr && go_bit && len_ok;
    assign go_bad  = wr && go_bit && !len_ok;
    assign go_busy = ack && go_bit && busy;
    assign w1c     = wr && off == 3'd2 && PSTRB[0];
    assign mask    = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign PREADY  = ack;
    assign PSLVERR = ack && slverr;
    assign PRDATA  = (ack && !PWRITE && !slverr) ? rdata : 32'd0;

    always_comb begin
        apb_next = IDLE;
        if (apb_state == IDLE && PSEL && !PENABLE)
            apb_next = ACCESS_WAIT;
        else if (apb_state == ACCESS_WAIT)
            apb_next = ACCESS_ACK;
        job_next = job_state;
        if (busy && eng_done)
            job_next = JOB_IDLE;
        else if (accept)
            job_next = JOB_RUN;
        rdata = 32'd0;
        case (off)
            3'd0:    rdata = P_VERSION;
            3'd1:    rdata = {30'd0, ie, 1'b0};
            3'd2:    rdata = {29'd0, err, done, busy};
            3'd3:    rdata = eng_src;
            3'd4:    rdata = eng_dst;
            3'd5:    rdata = eng_len;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            apb_state <= IDLE;
            job_state <= JOB_IDLE;
            eng_go    <= 1'b0;
            irq       <= 1'b0;
            ie        <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            eng_src   <= 32'd0;
            eng_dst   <= 32'd0;
            eng_len   <= 32'd0;
        end else begin
            apb_state <= apb_next;
            job_state <= job_next;
            eng_go    <= accept;
            irq       <= ie && (done || err);
            if (wr && off == 3'd1 && PSTRB[0])
                ie <= PWDATA[1];
            if (wr && off == 3'd3)
                eng_src <= (eng_src & ~mask) | (PWDATA & mask);
            if (wr && off == 3'd4)
                eng_dst <= (eng_dst & ~mask) | (PWDATA & mask);
            if (wr && off == 3'd5)
                eng_len <= (eng_len & ~mask) | (PWDATA & mask);
            // Engine completion is ORed in last so it wins over a same-cycle W1C.
            done <= (busy && eng_done) || (done && !(w1c && PWDATA[1]) && !accept);
            err  <= (busy && eng_done && eng_err) || go_bad || go_busy ||
                    (err && !(w1c && PWDATA[2]) && !accept);
        end
    end
endmodule

// File: tb/tb_dpu_apb_csr.sv
// tb_dpu_apb_csr: directed bench for dpu_apb_csr with a transaction-level register model
module tb_dpu_apb_csr;
    localparam logic [31:0] VER  = 32'h2025_0610;
    localparam logic [31:0] LMAX = 32'h0010_0000;

    logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, eng_done, eng_err;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA, eng_src, eng_dst, eng_len;
    logic        PREADY, PSLVERR, eng_go, irq;

    int checks = 0, errors = 0, go_cnt = 0;
    bit started = 0;

    // register model and per-cycle expected outputs
    logic [31:0] m_src, m_dst, m_len;
    logic        m_ie, m_busy, m_done, m_err;
    logic [31:0] exp_rdata;
    logic        exp_ready, exp_slverr, exp_go, exp_irq;
    bit          pend, p_wr;
    logic [31:0] p_a, p_d;
    logic [3:0]  p_s;
    logic [31:0] rd;
    logic        se;
    logic [31:0] lens [3];

    dpu_apb_csr dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .eng_go(eng_go), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
        .eng_done(eng_done), .eng_err(eng_err), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (eng_go === 1'b1) go_cnt++;
        if (started) begin
            chk("PREADY", {31'd0, PREADY}, {31'd0, exp_ready});
            chk("PRDATA", PRDATA, exp_rdata);
            chk("PSLVERR", {31'd0, PSLVERR}, {31'd0, exp_slverr});
            chk("eng_go", {31'd0, eng_go}, {31'd0, exp_go});
            chk("irq", {31'd0, irq}, {31'd0, exp_irq});
            chk("eng_src", eng_src, m_src);
            chk("eng_dst", eng_dst, m_dst);
            chk("eng_len", eng_len, m_len);
        end
    end

    function automatic bit legal(input logic [31:0] l);
        return l != 0 && l % 4 == 0 && l <= LMAX;
    endfunction

    function automatic bit bad(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int o = int'(a[4:2]);
        return o > 5 || (w && o == 0) || (w && m_busy && o >= 3) || (w && o == 1 && s[0] && d[0] && m_busy);
    endfunction

    function automatic logic [31:0] reg_val(input int o);
        logic [31:0] r [8] = '{VER, {30'd0, m_ie, 1'b0}, {29'd0, m_err, m_done, m_busy}, m_src, m_dst, m_len, 32'd0, 32'd0};
        return r[o];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic apply(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int o = int'(a[4:2]);
        if (!w) return;
        if (bad(w, a, d, s)) begin
            if (o == 1 && s[0] && d[0]) m_err = 1;
            return;
        end
        if (o == 1 && s[0]) begin
            m_ie = d[1];
            if (d[0] && legal(m_len)) begin
                m_busy = 1; m_done = 0; m_err = 0; exp_go = 1;
            end else if (d[0]) m_err = 1;
        end
        if (o == 2 && s[0]) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_err = 0;
        end
        if (o == 3) m_src = merge(m_src, d, s);
        if (o == 4) m_dst = merge(m_dst, d, s);
        if (o == 5) m_len = merge(m_len, d, s);
    endtask

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_len = 0; m_ie = 0; m_busy = 0; m_done = 0; m_err = 0;
        exp_rdata = 0; exp_ready = 0; exp_slverr = 0; exp_go = 0; exp_irq = 0; pend = 0;
    endtask

    // advance past one rising edge and move the model across it
    task automatic step();
        @(posedge PCLK);
        #1;
        exp_irq = m_ie & (m_done | m_err);
        exp_ready = 0; exp_rdata = 0; exp_slverr = 0; exp_go = 0;
        if (pend) begin
            apply(p_wr, p_a, p_d, p_s);
            pend = 0;
        end
        if (eng_done && m_busy) begin
            m_busy = 0; m_done = 1;
            if (eng_err) m_err = 1;
        end
        eng_done = 0; eng_err = 0;
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit dn, output logic [31:0] r, output logic e);
        PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
        step();
        PENABLE = 1;
        step();
        exp_ready = 1;
        exp_slverr = bad(w, a, d, s);
        exp_rdata = (w || exp_slverr) ? 32'd0 : reg_val(int'(a[4:2]));
        if (dn) eng_done = 1;
        pend = 1; p_wr = w; p_a = a; p_d = d; p_s = s;
        @(negedge PCLK);
        r = PRDATA; e = PSLVERR;
        step();
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        PSEL = 0; PENABLE = 0; PADDR = 0; PWRITE = 0; PWDATA = 0; PSTRB = 0;
        eng_done = 0; eng_err = 0; PRESET = 0;
        #2 PRESET = 1;
        model_reset();
        started = 1;
        step(); step();
        PRESET = 0;
        step();
        // version register, address low bits ignored, write rejected
        xfer(0, 32'h00, 0, 4'hF, 0, rd, se); chk("ver_rd", rd, VER); chk("ver_se", {31'd0, se}, 0);
        xfer(0, 32'h03, 0, 4'hF, 0, rd, se); chk("ver_lowbits", rd, VER);
        xfer(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 0, rd, se); chk("ver_wr_se", {31'd0, se}, 1);
        // descriptor and start
        xfer(1, 32'h0C, 32'h1000, 4'hF, 0, rd, se);
        xfer(1, 32'h10, 32'h2000, 4'hF, 0, rd, se);
        xfer(1, 32'h14, 32'h40, 4'hF, 0, rd, se);
        xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se);
        step(); step();
        chk("go_cnt1", go_cnt, 1);
        chk("src", eng_src, 32'h1000); chk("dst", eng_dst, 32'h2000); chk("len", eng_len, 32'h40);
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_busy", rd, 32'h1);
        // writes while busy
        xfer(1, 32'h14, 32'h80, 4'hF, 0, rd, se); chk("len_busy_se", {31'd0, se}, 1);
        chk("len_kept", eng_len, 32'h40);
        xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se); chk("go_busy_se", {31'd0, se}, 1);
        step();
        chk("go_cnt_busy", go_cnt, 1);
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_busy_err", rd, 32'h5);
        eng_done = 1;
        step(); step();
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_done", rd, 32'h6);
        chk("irq_on", {31'd0, irq}, 1);
        // W1C racing completion
        xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se);
        step(); step();
        chk("go_cnt2", go_cnt, 2); chk("irq_cleared_by_go", {31'd0, irq}, 0);
        xfer(1, 32'h08, 32'h6, 4'hF, 1, rd, se);
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("done_wins", rd, 32'h2);
        xfer(1, 32'h08, 32'h6, 4'hF, 0, rd, se);
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_clr", rd, 32'h0);
        chk("irq_off", {31'd0, irq}, 0);
        eng_done = 1; eng_err = 1;
        step();
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("done_idle_ignored", rd, 32'h0);
        // illegal lengths
        lens = '{32'h41, 32'h0, LMAX + 4};
        foreach (lens[i]) begin
            xfer(1, 32'h14, lens[i], 4'hF, 0, rd, se);
            xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se); chk("bad_len_se", {31'd0, se}, 0);
            xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("bad_len_status", rd, 32'h4);
            xfer(1, 32'h08, 32'h4, 4'hF, 0, rd, se);
        end
        step();
        chk("go_cnt_badlen", go_cnt, 2);
        // largest legal length, engine reports an error
        xfer(1, 32'h14, LMAX, 4'hF, 0, rd, se);
        xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se);
        step();
        chk("go_cnt_lmax", go_cnt, 3);
        eng_done = 1; eng_err = 1;
        step();
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_eng_err", rd, 32'h6);
        xfer(1, 32'h04, 32'h1, 4'b1110, 0, rd, se);
        step();
        chk("go_no_strb0", go_cnt, 3);
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("status_no_strb0", rd, 32'h6);
        // unmapped, byte strobes, reset mid-job
        xfer(0, 32'h18, 0, 4'hF, 0, rd, se); chk("unmap_se", {31'd0, se}, 1); chk("unmap_rd", rd, 0);
        xfer(1, 32'h1C, 32'h1234, 4'hF, 0, rd, se); chk("unmap_wr_se", {31'd0, se}, 1);
        xfer(1, 32'h0C, 32'h0, 4'hF, 0, rd, se);
        xfer(1, 32'h0C, 32'hAABB_CCDD, 4'b0010, 0, rd, se);
        xfer(0, 32'h0C, 0, 4'hF, 0, rd, se); chk("strb_src", rd, 32'h0000_CC00);
        xfer(1, 32'h14, 32'h40, 4'hF, 0, rd, se);
        xfer(1, 32'h04, 32'h3, 4'hF, 0, rd, se);
        step(); step();
        chk("go_cnt_last", go_cnt, 4);
        PRESET = 1;
        model_reset();
        step();
        chk("rst_src", eng_src, 0); chk("rst_len", eng_len, 0); chk("rst_irq", {31'd0, irq}, 0);
        step();
        PRESET = 0;
        step();
        xfer(0, 32'h08, 0, 4'hF, 0, rd, se); chk("rst_status", rd, 0);
        xfer(0, 32'h04, 0, 4'hF, 0, rd, se); chk("rst_control", rd, 0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dpu_apb_csr.md
Name: dpu_apb_csr

Overview:
APB completer (responder) register block for one DPU engine. It sits on the APB side of the AXI-to-APB bridge, one instance per engine slot (S0..S3). It decodes bridge-initiated reads and writes, holds the job descriptor, and issues a start pulse to the engine. It tracks busy/done/error and raises a level interrupt.

Parameters:
P_ADDR_WIDTH, 32, PADDR width; only PADDR[4:2] decoded, PADDR[1:0] ignored
P_VERSION, 32'h2025_0610, value of read-only VERSION register
P_LEN_MAX, 32'h0010_0000, largest legal NUM_BYTES

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PADDR  in  P_ADDR_WIDTH  byte address
PWRITE  in  1  1=write
PWDATA  in  32  write data
PSTRB  in  4  byte strobes (APB4)
PRDATA  out  32  read data, valid when PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid when PREADY=1
eng_go  out  1  one-cycle start pulse to engine
eng_src  out  32  source address (SRC_ADDR)
eng_dst  out  32  destination address (DST_ADDR)
eng_len  out  32  byte count (NUM_BYTES)
eng_done  in  1  one-cycle completion pulse from engine
eng_err  in  1  one-cycle engine error pulse, valid with eng_done
irq  out  1  interrupt, level

Behaviour:
- Reset (async assert, sync release): PRDATA=0, PREADY=0, PSLVERR=0, eng_go=0, all registers 0, irq=0, FSMs in IDLE.
- Register map (offset): 0x00 VERSION RO; 0x04 CONTROL [0]GO write-1 self-clearing, reads 0; [1]IE RW. 0x08 STATUS [0]BUSY RO; [1]DONE W1C; [2]ERR W1C. 0x0C SRC_ADDR RW; 0x10 DST_ADDR RW; 0x14 NUM_BYTES RW. 0x18/0x1C unmapped.
- APB FSM: IDLE -> (PSEL&!PENABLE) SETUP -> ACCESS_WAIT (PREADY=0, exactly one wait state) -> ACCESS_ACK (PREADY=1 for one cycle, PRDATA/PSLVERR driven) -> IDLE. Every transfer completes in 3 cycles from setup. PREADY is never held high for more than one cycle.
- Outside ACK, PRDATA=0 and PSLVERR=0.
- Writes commit on the ACK cycle only. PSTRB masks bytes of RW registers. GO/W1C bits are acted on only if PSTRB[0]=1.
- PSLVERR=1 in these cases, with no state change and read data 0:
  - unmapped offset;
  - write to VERSION;
  - write to SRC/DST/NUM_BYTES while BUSY=1.
- GO accepted when BUSY=0 and NUM_BYTES legal (nonzero, [1:0]==0, <=P_LEN_MAX):
  - eng_go=1 the cycle after ACK, for exactly 1 cycle;
  - BUSY set in the same cycle;
  - DONE and ERR cleared.
- GO with illegal NUM_BYTES: no eng_go, ERR set, PSLVERR=0.
- GO while BUSY=1: ignored, ERR set, PSLVERR=1.
- Job FSM: IDLE -> (GO accepted) RUN -> (eng_done) IDLE.
  - On eng_done: BUSY cleared, DONE set, ERR |= eng_err.
  - eng_done in IDLE is ignored.
- Simultaneous eng_done and a W1C write of DONE/ERR: set wins.
- irq = IE & (DONE | ERR), registered, one-cycle latency from the status change.
- eng_src/eng_dst/eng_len are direct register outputs. They are stable while BUSY because writes to them are blocked.
- PRESET mid-job aborts the descriptor and status only. The engine is reset by the same PRESET.
- Back-to-back transfers, where PSEL stays high into the next SETUP, are accepted from IDLE on the cycle after ACK.

Test Plan:
1. Reset, then read 0x00 -> PREADY high on the 3rd cycle, PRDATA=32'h2025_0610, PSLVERR=0. Write 0x00 -> PSLVERR=1.
2. Write SRC=0x1000, DST=0x2000, LEN=0x40, then CONTROL=0x3 -> eng_go pulses exactly one cycle after ACK. eng_src=0x1000, eng_dst=0x2000, eng_len=0x40, STATUS reads 0x1.
3. During BUSY, write LEN=0x80 -> PSLVERR=1, eng_len stays 0x40. Write GO -> PSLVERR=1, no eng_go, ERR=1. Then eng_done -> STATUS=0x6, irq=1 one cycle later.
4. Write STATUS=0x6 in the same cycle as an eng_done pulse -> DONE stays 1. Write STATUS=0x6 again -> STATUS=0, irq drops.
5. LEN=0x41, GO -> no eng_go, STATUS=0x4. LEN=0 -> same response. LEN=P_LEN_MAX+4 -> same response.
6. Read 0x18 -> PSLVERR=1, PRDATA=0. Write SRC with PSTRB=4'b0010, PWDATA=0xAABBCCDD over SRC=0 -> SRC=0x0000CC00. Assert PRESET mid-RUN -> all outputs 0, BUSY=0.
